// File: rtl/alu_sequencer.sv
// Sequences one operation through an external ALU: operands are latched,
// the ALU is driven for one cycle, and decimal ADC/SBC get a per-nibble correction.
module alu_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] op,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   input  logic       c_in,
   input  logic       d_flag,
   input  logic       flush,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_cin,
   output logic       alu_dec_add,
   input  logic [7:0] alu_out,
   input  logic       alu_cout,
   input  logic       alu_hcout,
   input  logic       alu_vout,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       n_out,
   output logic       v_out,
   output logic       z_out,
   output logic       c_out
);

   localparam logic [3:0] ALU_ORA = 4'd0;
   localparam logic [3:0] ALU_AND = 4'd1;
   localparam logic [3:0] ALU_EOR = 4'd2;
   localparam logic [3:0] ALU_ADC = 4'd3;
   localparam logic [3:0] ALU_SBC = 4'd4;
   localparam logic [3:0] ALU_ROR = 4'd5;
   localparam logic [3:0] ALU_PSA = 4'd6;

   typedef enum logic [1:0] {IDLE, EXEC, ADJ, DONE} state_t;

   state_t     state, next_state;
   logic [3:0] op_q;
   logic [7:0] a_q, b_q;
   logic       c_q, d_q;
   logic [7:0] out_q;
   logic       cout_q, hcout_q, vout_q;

   logic       is_arith, is_dec;
   logic [3:0] op_norm;
   logic [3:0] lo_corr, hi_corr;
   logic [7:0] adj_res, final_res;
   logic       final_c, final_v;

   assign is_arith = (op_q == ALU_ADC) || (op_q == ALU_SBC);
   assign is_dec   = is_arith && d_q;

   // Unknown opcodes are folded into PSA at latch time so the ALU never sees them.
   always_comb begin
      case (op)
         ALU_ORA, ALU_AND, ALU_EOR, ALU_ADC,
         ALU_SBC, ALU_ROR, ALU_PSA: op_norm = op;
         default:                   op_norm = ALU_PSA;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) next_state = EXEC;
            EXEC:    next_state = is_dec ? ADJ : DONE;
            ADJ:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      alu_a       = 8'h00;
      alu_b       = 8'h00;
      alu_op      = 4'h0;
      alu_cin     = 1'b0;
      alu_dec_add = 1'b0;
      if (state == EXEC) begin
         alu_a       = a_q;
         alu_b       = (op_q == ALU_SBC) ? ~b_q : b_q;
         alu_op      = op_q;
         alu_cin     = c_q;
         alu_dec_add = is_dec;
      end
   end

   // Decimal ADC adds 6 to a nibble that carried; decimal SBC adds 0xA to one that borrowed.
   always_comb begin
      if (op_q == ALU_ADC) begin
         lo_corr = hcout_q ? 4'h6 : 4'h0;
         hi_corr = cout_q  ? 4'h6 : 4'h0;
      end else begin
         lo_corr = hcout_q ? 4'h0 : 4'hA;
         hi_corr = cout_q  ? 4'h0 : 4'hA;
      end
      adj_res   = {out_q[7:4] + hi_corr, out_q[3:0] + lo_corr};
      final_res = (state == EXEC) ? alu_out  : adj_res;
      final_c   = (state == EXEC) ? alu_cout : cout_q;
      final_v   = (state == EXEC) ? alu_vout : vout_q;
      if (!is_arith && (op_q != ALU_ROR)) final_c = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q    <= 4'h0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         c_q     <= 1'b0;
         d_q     <= 1'b0;
         out_q   <= 8'h00;
         cout_q  <= 1'b0;
         hcout_q <= 1'b0;
         vout_q  <= 1'b0;
         result  <= 8'h00;
         n_out   <= 1'b0;
         v_out   <= 1'b0;
         z_out   <= 1'b0;
         c_out   <= 1'b0;
      end else begin
         if (state == IDLE && start && !flush) begin
            op_q <= op_norm;
            a_q  <= a_in;
            b_q  <= b_in;
            c_q  <= c_in;
            d_q  <= d_flag;
         end
         if (state == EXEC && !flush) begin
            out_q   <= alu_out;
            cout_q  <= alu_cout;
            hcout_q <= alu_hcout;
            vout_q  <= alu_vout;
         end
         // Flush forces next_state to IDLE, so a flushed operation never lands here.
         if (next_state == DONE && state != DONE) begin
            result <= final_res;
            n_out  <= final_res[7];
            z_out  <= (final_res == 8'h00);
            c_out  <= final_c;
            if (is_arith) v_out <= final_v;
         end
      end
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  operation request, sampled only while busy=0.
REQ-004 SHALL have port: op  input  4  ALU opcode from the shared ALU_* defines (ORA, AND, EOR, ADC, SBC, ROR, PSA).
REQ-005 SHALL have ports: a_in, b_in  input  8 each  operands; c_in  input  1  carry flag in; d_flag  input  1  decimal mode.
REQ-006 SHALL have port: flush  input  1  synchronous abort of the current operation.
REQ-007 SHALL have ALU drive ports: alu_a, alu_b  output  8; alu_op  output  4; alu_cin, alu_dec_add  output  1.
REQ-008 SHALL have ALU return ports: alu_out  input  8; alu_cout, alu_hcout, alu_vout  input  1.
REQ-009 SHALL have ports: busy  output  1; done  output  1 (one-cycle pulse); result  output  8; n_out, v_out, z_out, c_out  output  1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, ADJ and DONE.
REQ-011 SHALL, in IDLE with start=1 and flush=0, latch op, a_in, b_in, c_in and d_flag, then go to EXEC; start SHALL be ignored in every other state.
REQ-012 SHALL, in EXEC, drive alu_a=latched a and alu_op=latched op with alu_cin=latched c; alu_b SHALL be latched b, or ~b for SBC.
REQ-013 SHALL assert alu_dec_add only in EXEC, only for ADC/SBC, and only with latched d_flag=1; alu_dec_add SHALL be 0 at all other times.
REQ-014 SHALL, at the end of EXEC, register alu_out, alu_cout, alu_hcout and alu_vout.
REQ-015 SHALL go EXEC->ADJ for decimal ADC/SBC and EXEC->DONE otherwise.
REQ-016 SHALL, in ADJ, apply a per-nibble correction modulo 16 using the registered half-carry for the low nibble and the registered carry for the high nibble.
REQ-017 SHALL use correction +6 for decimal ADC when that nibble's carry=1, +0xA for decimal SBC when that nibble's carry=0, and 0 otherwise; ADJ then goes to DONE.
REQ-018 SHALL update result and flags on entry to DONE and hold them until the next completed operation.
REQ-019 SHALL compute flags as: n_out=result[7]; z_out=(result==0); c_out=registered alu_cout; v_out=registered alu_vout for ADC/SBC, otherwise unchanged.
REQ-020 SHALL, for ORA, AND, EOR and PSA, force c_out=0 (ALU carry=0).
REQ-021 SHALL, for ROR, produce result {c,a[7:1]} and c_out=a[0], taken from the ALU.
REQ-022 SHALL hold busy=1 in EXEC, ADJ and DONE, and busy=0 in IDLE.
REQ-023 SHALL hold done=1 only in DONE; DONE SHALL always return to IDLE next cycle.
REQ-024 SHALL give a latency from the start-sampling edge to done high of 2 cycles for binary/logic ops and 3 cycles for decimal ADC/SBC.
REQ-025 SHALL accept a new start on the cycle after DONE, giving back-to-back throughput of 1 op per 3 cycles (binary) or 4 cycles (decimal).
REQ-026 SHALL, on flush=1 in any state, go to IDLE next edge with no done pulse and with result and flags unchanged.
REQ-027 SHALL give flush priority when flush and start are both high in IDLE, so the start is dropped.
REQ-028 SHALL treat an undefined op code as PSA.
REQ-029 SHALL drive alu_* outputs to 0 in IDLE and DONE.

Reset
REQ-030 SHALL, while reset=1 (async assert, mid-operation included), set state=IDLE, busy=0, done=0, result=0x00, all flags=0 and all alu_* outputs=0.
REQ-031 SHALL accept no start while reset is asserted; the first start is sampled on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL cover binary ADC: 0x50+0x50, c=0, d=0 -> result 0xA0, N=1, V=1, C=0, Z=0, done 2 cycles after start.
REQ-033 SHALL cover decimal ADC: 0x19+0x28, c=0 -> 0x47, C=0, done at 3 cycles; 0x58+0x46, c=1 -> 0x05, C=1, Z=0.
REQ-034 SHALL cover decimal SBC: 0x40-0x13, c=1 -> 0x27, C=1, N=0; binary ADC 0xFF+0x01, c=0 -> 0x00, Z=1, C=1.
REQ-035 SHALL cover ROR: a=0x81, c_in=1 -> 0xC0, C=1, N=1; ORA 0x0F|0xF0 with c_in=1 -> 0xFF, C=0.
REQ-036 SHALL cover flush and start: flush in ADJ -> IDLE next cycle, no done, prior result held; start while busy ignored; start+flush in IDLE -> no op.
REQ-037 SHALL cover reset asserted in EXEC -> busy=0, result=0x00, flags=0 immediately; a clean op completes after release.
